spi_adc_responder: RTL and testbench

//  SPI responder (slave) emulating the 12-bit serial ADC read by the SPI_state_machine master.

---
 rtl/spi_adc_pkg.sv | 17 +
 rtl/spi_sync_edge.sv | 38 +++
 rtl/spi_adc_responder.sv | 236 +++++++++++++++++++++++
 tb/tb_spi_adc_responder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_adc_pkg.sv
// Shared definitions for the SPI ADC responder: default frame geometry and FSM states.
// Build option: SPI_ADC_RAMP_EN replaces the external sample with an internal ramp.
package spi_adc_pkg;

  localparam int unsigned SPI_DATA_W      = 12;
  localparam int unsigned SPI_LEAD_ZEROS  = 4;
  localparam int unsigned SPI_FRAME_BITS  = 16;
  localparam int unsigned SPI_SYNC_STAGES = 2;
  localparam int unsigned TRAIL_ZEROS     = SPI_FRAME_BITS - SPI_LEAD_ZEROS - SPI_DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage : spi_adc_pkg

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input with edge detection.
// Ports:
//   clk, rst_n  system clock, async active-low reset
//   async_i     asynchronous input pin
//   level_o     synchronized level (last flop of the chain)
//   rise_c_o    combinational 1-cycle pulse on synchronized rising edge
//   fall_c_o    combinational 1-cycle pulse on synchronized falling edge
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchronizer chain plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o  = sync_q[STAGES-1];
  assign rise_c_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_c_o = ~sync_q[STAGES-1] & prev_q;

endmodule : spi_sync_edge

// File: rtl/spi_adc_responder.sv
// SPI mode-0 responder emulating a 12-bit serial ADC. Each frame shifts out
// LEAD_ZEROS zeros, the sample MSB-first, then trailing zeros, and captures
// the MOSI bits of the frame. All SPI pins are oversampled by clk.
// Build option: define SPI_ADC_RAMP_EN to transmit an internal ramp that
// increments after every complete frame instead of i_sample.
// Ports:
//   clk, rst_n      system clock (>= 8x SCK), async active-low reset
//   sck, cs_n, mosi SPI pins from the master (asynchronous)
//   i_sample        sample to transmit, latched at frame start
//   miso, miso_oe   serial data to master and its output enable
//   o_rx_data       MOSI bits of the last complete frame, first bit in MSB
//   o_rx_valid      pulse: complete frame ended, o_rx_data updated
//   o_frame_err     pulse: frame ended before FRAME_BITS rising edges
//   o_busy          high from frame start until frame end
module spi_adc_responder
  import spi_adc_pkg::*;
#(
  parameter int unsigned DATA_W      = SPI_DATA_W,
  parameter int unsigned LEAD_ZEROS  = SPI_LEAD_ZEROS,
  parameter int unsigned FRAME_BITS  = SPI_FRAME_BITS,
  parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sck,
  input  logic                  cs_n,
  input  logic                  mosi,
  input  logic [DATA_W-1:0]     i_sample,
  output logic                  miso,
  output logic                  miso_oe,
  output logic [FRAME_BITS-1:0] o_rx_data,
  output logic                  o_rx_valid,
  output logic                  o_frame_err,
  output logic                  o_busy
);

  localparam int unsigned TRAIL_BITS = FRAME_BITS - LEAD_ZEROS - DATA_W;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);

  // Synchronized pins
  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  // cs_n synchronizer resets to the deselected level so reset release never
  // looks like a chip-select edge.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_i  (sck),
    .level_o  (sck_lvl),
    .rise_c_o (sck_rise),
    .fall_c_o (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_i  (cs_n),
    .level_o  (cs_lvl),
    .rise_c_o (cs_rise),
    .fall_c_o (cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_i  (mosi),
    .level_o  (mosi_lvl),
    .rise_c_o (mosi_rise),
    .fall_c_o (mosi_fall)
  );

  // State and datapath registers
  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] tx_sr_q, tx_sr_d;
  logic [FRAME_BITS-1:0] rx_sr_q, rx_sr_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  pend_q, pend_d;
  logic                  miso_q, miso_d;
  logic                  miso_oe_q, miso_oe_d;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  busy_q, busy_d;

  logic [DATA_W-1:0]     sample_c;
  logic [FRAME_BITS-1:0] tx_load_c;
  logic                  start_c;
  logic                  frame_full_c;

`ifdef SPI_ADC_RAMP_EN
  logic [DATA_W-1:0] ramp_q, ramp_d;

  // Ramp advances once per complete frame, wrapping naturally.
  always_comb begin
    ramp_d = ramp_q;
    if (rx_valid_d) begin
      ramp_d = ramp_q + DATA_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp_q <= '0;
    end else begin
      ramp_q <= ramp_d;
    end
  end

  assign sample_c = ramp_q;

  logic unused_ok;
  assign unused_ok = ^{sck_lvl, mosi_rise, mosi_fall, i_sample};
`else
  assign sample_c = i_sample;

  logic unused_ok;
  assign unused_ok = ^{sck_lvl, mosi_rise, mosi_fall};
`endif

  // Frame image: leading zeros, sample MSB-first, trailing zeros.
  assign tx_load_c    = FRAME_BITS'(sample_c) << TRAIL_BITS;
  // A cs_n fall seen during DONE is replayed once IDLE is reached.
  assign start_c      = cs_fall | (pend_q & ~cs_lvl);
  assign frame_full_c = (bit_cnt_q == CNT_W'(FRAME_BITS));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; cs_n rise takes priority over any SCK edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_c) state_d = ST_SHIFT;
      ST_SHIFT: if (cs_rise) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM output and datapath next values
  always_comb begin
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    bit_cnt_d   = bit_cnt_q;
    pend_d      = 1'b0;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    busy_d      = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          tx_sr_d   = tx_load_c;
          rx_sr_d   = '0;
          bit_cnt_d = '0;
          miso_d    = tx_load_c[FRAME_BITS-1];
          miso_oe_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          miso_d    = 1'b0;
          miso_oe_d = 1'b0;
          busy_d    = 1'b0;
          if (frame_full_c) begin
            rx_data_d  = rx_sr_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          // Rising edges past FRAME_BITS are not captured.
          if (sck_rise && !frame_full_c) begin
            rx_sr_d   = {rx_sr_q[FRAME_BITS-2:0], mosi_lvl};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
          if (sck_fall) begin
            tx_sr_d = {tx_sr_q[FRAME_BITS-2:0], 1'b0};
            miso_d  = tx_sr_q[FRAME_BITS-2];
          end
        end
      end
      ST_DONE: begin
        pend_d = cs_fall;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      bit_cnt_q   <= '0;
      pend_q      <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      pend_q      <= pend_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;
  assign o_rx_data   = rx_data_q;
  assign o_rx_valid  = rx_valid_q;
  assign o_frame_err = frame_err_q;
  assign o_busy      = busy_q;

endmodule : spi_adc_responder

// File: tb/tb_spi_adc_responder.sv
// Directed bench for spi_adc_responder acting as an SPI mode-0 master with
// SCK = clk/8. Expected read words are queued before each frame and popped
// when the frame completes. Define SPI_ADC_RAMP_EN to exercise the ramp build.
module tb_spi_adc_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic [11:0] i_sample = '0;
  logic        miso, miso_oe, o_rx_valid, o_frame_err, o_busy;
  logic [15:0] o_rx_data;

  int tests  = 0;
  int failed = 0;
  logic [31:0] exp_q[$];

  spi_adc_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sck         (sck),
    .cs_n        (cs_n),
    .mosi        (mosi),
    .i_sample    (i_sample),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .o_rx_data   (o_rx_data),
    .o_rx_valid  (o_rx_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_start();
    @(negedge clk);
    cs_n = 1'b0;
    tick(5);
  endtask

  // One SCK period; master samples miso just before the rising edge.
  task automatic sck_bit(input logic b, output logic m);
    mosi = b;
    tick(4);
    m = miso;
    sck = 1'b1;
    tick(4);
    sck = 1'b0;
  endtask

  // Deselect and count end-of-frame pulses inside a bounded window.
  task automatic cs_end(output int nv, output int ne);
    tick(4);
    cs_n = 1'b1;
    nv = 0;
    ne = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_rx_valid)  nv++;
      if (o_frame_err) ne++;
    end
  endtask

  task automatic run_frame(input int nbits, input logic [31:0] mosi_word,
                           output logic [31:0] rd, output int nv, output int ne);
    logic b;
    rd = '0;
    cs_start();
    for (int i = 0; i < nbits; i++) begin
      sck_bit(mosi_word[nbits-1-i], b);
      rd = {rd[30:0], b};
    end
    cs_end(nv, ne);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cs_n  = 1'b1;
    sck   = 1'b0;
    mosi  = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] expw;
    logic        b;
    int          nv, ne;

    // Reset state
    tick(3);
    check("rst_miso",     32'(miso),        32'h0);
    check("rst_miso_oe",  32'(miso_oe),     32'h0);
    check("rst_rx_data",  32'(o_rx_data),   32'h0);
    check("rst_rx_valid", 32'(o_rx_valid),  32'h0);
    check("rst_frame_err",32'(o_frame_err), 32'h0);
    check("rst_busy",     32'(o_busy),      32'h0);
    rst_n = 1'b1;
    tick(3);

`ifdef SPI_ADC_RAMP_EN
    // Ramp: three complete frames, one short frame, one complete frame.
    i_sample = 12'hABC;
    for (int f = 0; f < 3; f++) begin
      exp_q.push_back(32'(f));
      run_frame(16, 32'h1234, rd, nv, ne);
      expw = exp_q.pop_front();
      check("ramp_read", rd, expw);
      check("ramp_valid", 32'(nv), 32'd1);
    end
    run_frame(9, 32'h1FF, rd, nv, ne);
    check("ramp_short_err", 32'(ne), 32'd1);
    check("ramp_short_valid", 32'(nv), 32'd0);
    exp_q.push_back(32'h0003);
    run_frame(16, 32'h4321, rd, nv, ne);
    expw = exp_q.pop_front();
    check("ramp_after_err", rd, expw);
    check("ramp_rx_data", 32'(o_rx_data), 32'h4321);
`else
    // 1: sample 0xA5C reads back as 16-bit word 0x0A5C
    i_sample = 12'hA5C;
    exp_q.push_back(32'h0000_0A5C);
    cs_start();
    check("t1_miso_oe", 32'(miso_oe), 32'h1);
    check("t1_busy",    32'(o_busy),  32'h1);
    rd = '0;
    for (int i = 0; i < 16; i++) begin
      sck_bit(1'b0, b);
      rd = {rd[30:0], b};
    end
    cs_end(nv, ne);
    expw = exp_q.pop_front();
    check("t1_read",  rd, expw);
    check("t1_valid", 32'(nv), 32'd1);
    check("t1_err",   32'(ne), 32'd0);
    check("t1_oe_off",32'(miso_oe), 32'h0);
    check("t1_busy_off", 32'(o_busy), 32'h0);

    // 2: MOSI capture
    i_sample = 12'h123;
    exp_q.push_back(32'h0000_0123);
    run_frame(16, 32'hC3E1, rd, nv, ne);
    expw = exp_q.pop_front();
    check("t2_read",    rd, expw);
    check("t2_rx_data", 32'(o_rx_data), 32'hC3E1);
    check("t2_valid",   32'(nv), 32'd1);
    check("t2_err",     32'(ne), 32'd0);

    // 3: short frame of 9 SCKs
    i_sample = 12'h7FF;
    exp_q.push_back(32'h0000_000F);
    run_frame(9, 32'h1FF, rd, nv, ne);
    expw = exp_q.pop_front();
    check("t3_read",    rd, expw);
    check("t3_err",     32'(ne), 32'd1);
    check("t3_valid",   32'(nv), 32'd0);
    check("t3_rx_held", 32'(o_rx_data), 32'hC3E1);
    check("t3_miso_oe", 32'(miso_oe), 32'h0);

    // 4: async reset mid-frame while miso drives a 1
    i_sample = 12'hFFF;
    cs_start();
    for (int i = 0; i < 7; i++) sck_bit(1'b1, b);
    tick(4);
    check("t4_pre_miso", 32'(miso), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t4_rst_miso",    32'(miso),      32'h0);
    check("t4_rst_oe",      32'(miso_oe),   32'h0);
    check("t4_rst_busy",    32'(o_busy),    32'h0);
    check("t4_rst_rx_data", 32'(o_rx_data), 32'h0);
    cs_n = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    i_sample = 12'h001;
    exp_q.push_back(32'h0000_0001);
    run_frame(16, 32'h5AA5, rd, nv, ne);
    expw = exp_q.pop_front();
    check("t4_read",    rd, expw);
    check("t4_valid",   32'(nv), 32'd1);
    check("t4_rx_data", 32'(o_rx_data), 32'h5AA5);

    // 5: sample changes mid-frame; 18 SCKs, extra bits read 0 and are not captured
    i_sample = 12'hFFF;
    exp_q.push_back(32'h0000_3FFC);
    cs_start();
    rd = '0;
    for (int i = 0; i < 18; i++) begin
      if (i == 4) i_sample = 12'h000;
      sck_bit((i < 16) ? expw[0] ^ ((32'h9ABC >> (15 - i)) & 1) ^ expw[0] : 1'b1, b);
      rd = {rd[30:0], b};
    end
    cs_end(nv, ne);
    expw = exp_q.pop_front();
    check("t5_read",    rd, expw);
    check("t5_valid",   32'(nv), 32'd1);
    check("t5_err",     32'(ne), 32'd0);
    check("t5_rx_data", 32'(o_rx_data), 32'h9ABC);
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_spi_adc_responder
